// File: rtl/fpu_pkg.sv
// Shared constants for the FPU divide sequencer: datapath function codes and FSM state encoding.
package fpu_pkg;

  localparam logic [2:0] FN_HOLD    = 3'd0;
  localparam logic [2:0] FN_LOAD    = 3'd1;
  localparam logic [2:0] FN_SHL     = 3'd2;
  localparam logic [2:0] FN_ADD_SHL = 3'd3;
  localparam logic [2:0] FN_SUB_SHL = 3'd4;
  localparam logic [2:0] FN_CLR     = 3'd5;
  localparam logic [2:0] FN_ADD     = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ITER  = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/fpu_divseq_cnt.sv
// Remaining-iteration down-counter for the divide sequencer.
// Priority: clear (abort) over freeze (stall) over load over decrement.
module fpu_divseq_cnt (
  input  logic       clk,
  input  logic       reset_l,
  input  logic       clr,
  input  logic       hold,
  input  logic       load,
  input  logic       dec,
  input  logic [5:0] load_val,
  output logic [5:0] cnt
);

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      cnt <= 6'd0;
    end else if (clr) begin
      cnt <= 6'd0;
    end else if (!hold) begin
      if (load) begin
        cnt <= load_val;
      end else if (dec) begin
        cnt <= cnt - 6'd1;
      end
    end
  end

endmodule

// File: rtl/fpu_divseq.sv
// Non-restoring mantissa divide sequencer: drives datapath function codes through LOAD/ITER/FIXUP.
// Optional early termination on a zero partial remainder is enabled by defining FPU_DIV_EARLY_TERM_EN.
module fpu_divseq
  import fpu_pkg::*;
#(
  parameter int SGL_ITER = 26,
  parameter int DBL_ITER = 55
) (
  input  logic       clk,
  input  logic       reset_l,
  input  logic       start,
  input  logic       dbl,
  input  logic       abort,
  input  logic       fpuhold,
  input  logic       a2,
  input  logic       manzero,
  output logic [2:0] a0func,
  output logic [2:0] a1func,
  output logic [2:0] a2func,
  output logic       busy,
  output logic       done,
  output logic [5:0] iter_cnt,
  output logic       exact,
  output logic [2:0] state_dbg
);

  localparam logic [5:0] SGL_LOAD = 6'(SGL_ITER - 1);
  localparam logic [5:0] DBL_LOAD = 6'(DBL_ITER - 1);

  state_t state, nxt;
  logic   dbl_q, done_q, busy_q, exact_q;
  logic   early_term;

`ifdef FPU_DIV_EARLY_TERM_EN
  assign early_term = manzero & ~a2;
`else
  logic unused_manzero;
  assign early_term     = 1'b0;
  assign unused_manzero = manzero;
`endif

  // Handshake: start is a one-cycle request honoured only in IDLE; done is a one-cycle
  // completion pulse, withheld while fpuhold is high and delivered on the first unstalled DONE cycle.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state <= ST_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (abort) begin
      nxt = ST_IDLE;
    end else if (!fpuhold) begin
      case (state)
        ST_IDLE:  if (start) nxt = ST_LOAD;
        ST_LOAD:  nxt = ST_ITER;
        ST_ITER: begin
          if (early_term)           nxt = ST_DONE;
          else if (iter_cnt == 6'd0) nxt = ST_FIXUP;
        end
        ST_FIXUP: nxt = ST_DONE;
        ST_DONE:  nxt = ST_IDLE;
        default:  nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    a0func = FN_HOLD;
    a1func = FN_HOLD;
    a2func = FN_HOLD;
    if (!fpuhold) begin
      case (state)
        ST_LOAD: begin
          a0func = FN_LOAD;
          a1func = FN_LOAD;
          a2func = FN_CLR;
        end
        ST_ITER: begin
          a0func = a2 ? FN_ADD_SHL : FN_SUB_SHL;
          a1func = a0func;
          a2func = a0func;
        end
        ST_FIXUP: begin
          // negative final remainder needs one restoring add
          a0func = a2 ? FN_ADD : FN_HOLD;
          a1func = a0func;
          a2func = a0func;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      dbl_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      exact_q <= 1'b0;
    end else begin
      done_q <= (nxt == ST_DONE);
      busy_q <= (nxt != ST_IDLE);
      if (state == ST_IDLE && nxt == ST_LOAD) dbl_q <= dbl;
      if (!fpuhold && !abort) begin
        if (state == ST_LOAD)                   exact_q <= 1'b0;
        else if (state == ST_ITER && early_term) exact_q <= 1'b1;
      end
    end
  end

  fpu_divseq_cnt u_cnt (
    .clk      (clk),
    .reset_l  (reset_l),
    .clr      (abort),
    .hold     (fpuhold),
    .load     (state == ST_LOAD),
    .dec      (state == ST_ITER && iter_cnt != 6'd0),
    .load_val (dbl_q ? DBL_LOAD : SGL_LOAD),
    .cnt      (iter_cnt)
  );

  assign done      = done_q & ~fpuhold;
  assign busy      = busy_q;
  assign exact     = exact_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_fpu_divseq.sv
// Directed bench for fpu_divseq: drivers push expected {exact, done cycle} into a queue,
// a monitor pops and compares on every done pulse; per-cycle function codes are checked inline.
module tb_fpu_divseq;
  import fpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset_l = 1'b0;
  logic       start = 1'b0, dbl = 1'b0, abort = 1'b0, fpuhold = 1'b0, a2 = 1'b0, manzero = 1'b0;
  logic [2:0] a0func, a1func, a2func, state_dbg;
  logic       busy, done, exact;
  logic [5:0] iter_cnt;
  logic [8:0] funcs;

  int         cyc = 0;
  int         total = 0;
  int         passed = 0;
  logic [16:0] exp_q[$];

  assign funcs = {a0func, a1func, a2func};

  fpu_divseq dut (
    .clk(clk), .reset_l(reset_l), .start(start), .dbl(dbl), .abort(abort),
    .fpuhold(fpuhold), .a2(a2), .manzero(manzero),
    .a0func(a0func), .a1func(a1func), .a2func(a2func),
    .busy(busy), .done(done), .iter_cnt(iter_cnt), .exact(exact), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] f3(input logic [2:0] f);
    return {f, f, f};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step(input logic st, input logic a2_v, input logic hold_v, input logic ab_v, input logic mz_v);
    @(posedge clk);
    #1;
    start = st; a2 = a2_v; fpuhold = hold_v; abort = ab_v; manzero = mz_v;
    @(negedge clk);
  endtask

  task automatic issue(input logic d, output int k);
    @(posedge clk);
    #1;
    start = 1'b1; dbl = d; a2 = 1'b0; fpuhold = 1'b0; abort = 1'b0; manzero = 1'b0;
    k = cyc;
    @(negedge clk);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset_l) begin
      chk("func_code_7", 16'({a0func == 3'd7, a1func == 3'd7, a2func == 3'd7}), 16'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 16'(cyc), 16'hffff);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          chk("done_cycle", 16'(cyc), e[15:0]);
          chk("done_exact", 16'(exact), 16'(e[16]));
        end
      end
    end
  end

  initial begin
    #200000;
    total++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    int k;
    int rem;
    logic hold_v;

    // reset state, observed before any clock edge
    #1;
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_iter", 16'(iter_cnt), 16'd0);
    chk("rst_exact", 16'(exact), 16'd0);
    chk("rst_funcs", 16'(funcs), 16'(f3(FN_HOLD)));
    chk("rst_state", 16'(state_dbg), 16'(ST_IDLE));
    #21 reset_l = 1'b1;
    step(0, 0, 0, 0, 0);

    // single precision, a2=0; a start while busy is ignored
    issue(0, k);
    exp_q.push_back({1'b0, 16'(k + 29)});
    chk("s1_c0_busy", 16'(busy), 16'd0);
    step(0, 0, 0, 0, 0);
    chk("s1_load_state", 16'(state_dbg), 16'(ST_LOAD));
    chk("s1_load_funcs", 16'(funcs), 16'({FN_LOAD, FN_LOAD, FN_CLR}));
    chk("s1_load_busy", 16'(busy), 16'd1);
    for (int i = 0; i < 26; i++) begin
      step(i == 5, 0, 0, 0, 0);
      chk("s1_iter_funcs", 16'(funcs), 16'(f3(FN_SUB_SHL)));
      chk("s1_iter_cnt", 16'(iter_cnt), 16'(25 - i));
    end
    step(0, 0, 0, 0, 0);
    chk("s1_fixup_state", 16'(state_dbg), 16'(ST_FIXUP));
    chk("s1_fixup_funcs", 16'(funcs), 16'(f3(FN_HOLD)));
    step(0, 0, 0, 0, 0);
    chk("s1_done_busy", 16'(busy), 16'd1);
    step(0, 0, 0, 0, 0);
    chk("s1_idle_busy", 16'(busy), 16'd0);

    // double precision, a2 toggling; FIXUP restore; start in DONE ignored
    issue(1, k);
    exp_q.push_back({1'b0, 16'(k + 58)});
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 55; i++) begin
      step(0, 1'(i % 2), 0, 0, 0);
      chk("s2_iter_funcs", 16'(funcs), 16'(f3((i % 2 == 1) ? FN_ADD_SHL : FN_SUB_SHL)));
      chk("s2_iter_cnt", 16'(iter_cnt), 16'(54 - i));
    end
    step(0, 1, 0, 0, 0);
    chk("s2_fixup_funcs", 16'(funcs), 16'(f3(FN_ADD)));
    step(1, 0, 0, 0, 0);
    chk("s2_done_state", 16'(state_dbg), 16'(ST_DONE));
    step(0, 0, 0, 0, 0);
    chk("s2_after_busy", 16'(busy), 16'd0);
    step(0, 0, 0, 0, 0);
    chk("s2_ignored_start", 16'(state_dbg), 16'(ST_IDLE));

    // stall 3 cycles mid-ITER, plus one stall cycle in DONE
    issue(0, k);
    exp_q.push_back({1'b0, 16'(k + 33)});
    step(0, 0, 0, 0, 0);
    rem = 25;
    for (int c = 2; c <= 30; c++) begin
      hold_v = (c >= 12 && c <= 14);
      step(0, 0, hold_v, 0, 0);
      chk("s3_iter_funcs", 16'(funcs), 16'(f3(hold_v ? FN_HOLD : FN_SUB_SHL)));
      chk("s3_iter_cnt", 16'(iter_cnt), 16'(rem));
      if (!hold_v) rem--;
    end
    step(0, 0, 0, 0, 0);
    chk("s3_fixup_state", 16'(state_dbg), 16'(ST_FIXUP));
    step(0, 0, 1, 0, 0);
    chk("s3_held_done", 16'(done), 16'd0);
    chk("s3_held_state", 16'(state_dbg), 16'(ST_DONE));
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("s3_idle_busy", 16'(busy), 16'd0);

    // abort mid-ITER, restart two cycles later
    issue(0, k);
    step(0, 0, 0, 0, 0);
    for (int c = 2; c <= 10; c++) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    chk("s4_abort_cycle_funcs", 16'(funcs), 16'(f3(FN_HOLD)));
    step(0, 0, 0, 0, 0);
    chk("s4_abort_state", 16'(state_dbg), 16'(ST_IDLE));
    chk("s4_abort_busy", 16'(busy), 16'd0);
    chk("s4_abort_funcs", 16'(funcs), 16'(f3(FN_HOLD)));
    issue(0, k);
    exp_q.push_back({1'b0, 16'(k + 29)});
    for (int c = 1; c <= 30; c++) step(0, 0, 0, 0, 0);
    chk("s4_restart_busy", 16'(busy), 16'd0);

    // zero remainder in the fifth ITER cycle
    issue(0, k);
`ifdef FPU_DIV_EARLY_TERM_EN
    exp_q.push_back({1'b1, 16'(k + 7)});
`else
    exp_q.push_back({1'b0, 16'(k + 29)});
`endif
    step(0, 0, 0, 0, 0);
    for (int c = 2; c <= 30; c++) begin
      step(0, 0, 0, 0, c == 6);
      if (c == 6) chk("s5_mz_funcs", 16'(funcs), 16'(f3(FN_SUB_SHL)));
      if (c == 8) begin
`ifdef FPU_DIV_EARLY_TERM_EN
        chk("s5_c8_busy", 16'(busy), 16'd0);
`else
        chk("s5_c8_busy", 16'(busy), 16'd1);
`endif
      end
    end

    // asynchronous reset mid-ITER
    issue(0, k);
    for (int c = 1; c <= 10; c++) step(0, 1, 0, 0, 0);
    @(posedge clk);
    #2 reset_l = 1'b0;
    #1;
    chk("s6_busy", 16'(busy), 16'd0);
    chk("s6_iter", 16'(iter_cnt), 16'd0);
    chk("s6_state", 16'(state_dbg), 16'(ST_IDLE));
    chk("s6_funcs", 16'(funcs), 16'(f3(FN_HOLD)));
    chk("s6_done", 16'(done), 16'd0);
    @(negedge clk);
    @(negedge clk);
    reset_l = 1'b1;
    for (int c = 0; c < 30; c++) step(0, 0, 0, 0, 0);

    chk("pending_expected", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fpu_divseq.md
FPU_DIVSEQ -- requirements
Module: fpu_divseq

Interface
REQ-001 Parameter: SGL_ITER, default 26, non-restoring iteration count for single-precision mantissa divide.
REQ-002 Parameter: DBL_ITER, default 55, iteration count for double precision; SHALL be at most 63.
REQ-003 Port: clk  input  1  sole clock, rising edge.
REQ-004 Port: reset_l  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  one-cycle divide request, sampled only in IDLE.
REQ-006 Port: dbl  input  1  precision select, sampled with start (1 = DBL_ITER).
REQ-007 Port: abort  input  1  synchronous flush request.
REQ-008 Port: fpuhold  input  1  pipeline stall.
REQ-009 Port: a2  input  1  remainder sign from the mantissa datapath (1 = negative).
REQ-010 Port: manzero  input  1  partial remainder is zero.
REQ-011 Port: a0func, a1func, a2func  output  3 each  datapath function codes.
REQ-012 Port: busy  output  1  high in every state except IDLE.
REQ-013 Port: done  output  1  one-cycle completion pulse.
REQ-014 Port: iter_cnt  output  6  remaining iterations.
REQ-015 Port: exact  output  1  early-termination flag, valid while done is high.

Function
REQ-016 Function codes: HOLD=0, LOAD=1, SHL=2, ADD_SHL=3, SUB_SHL=4, CLR=5, ADD=6; values 7 SHALL never be driven.
REQ-017 States: IDLE, LOAD, ITER, FIXUP, DONE; funcs decoded combinationally from state and a2; all other outputs registered.
REQ-018 IDLE: all funcs HOLD; start=1 -> LOAD; start while busy SHALL be ignored.
REQ-019 LOAD: a1func=a0func=LOAD, a2func=CLR; iter_cnt <= ITER-1 for the selected precision; next state ITER.
REQ-020 ITER: all three funcs SHALL be SUB_SHL when a2=0 and ADD_SHL when a2=1; iter_cnt decrements each cycle; when iter_cnt=0, next state FIXUP.
REQ-021 FIXUP: all funcs SHALL be ADD when a2=1 (remainder restore), HOLD otherwise; next state DONE.
REQ-022 DONE: done=1 for exactly one cycle; next state IDLE; a start in the DONE cycle SHALL be ignored.
REQ-023 Latency: start sampled in cycle 0 -> done in cycle 29 (single) or 58 (double), with no stalls.
REQ-024 fpuhold=1: state, iter_cnt, and exact SHALL be frozen; all funcs SHALL be HOLD; done SHALL be held off and delivered on the first unstalled DONE cycle.
REQ-025 abort=1 in any state: next state IDLE, done SHALL not pulse, funcs HOLD from the next cycle; abort has priority over fpuhold and start.
REQ-026 exact SHALL be cleared in LOAD.

Reset
REQ-027 reset_l=0 SHALL asynchronously force IDLE, iter_cnt=0, done=0, exact=0, busy=0; funcs then decode HOLD.
REQ-028 Reset mid-operation SHALL discard the divide with no done pulse.

Configuration
REQ-029 FPU_DIV_EARLY_TERM_EN defined: in ITER with manzero=1 and a2=0, the block SHALL go directly to DONE with exact=1.
REQ-030 FPU_DIV_EARLY_TERM_EN undefined: manzero is ignored, exact SHALL stay 0, and the full iteration count always runs.

Structure
REQ-031 Function-code constants and the state encoding SHALL reside in the shared package fpu_pkg.
REQ-032 The iteration down-counter, with its load, decrement and freeze logic, SHALL be the sub-module fpu_divseq_cnt; the FSM stays in fpu_divseq.

Verification
REQ-033 Single precision, a2 held 0, no stalls -> LOAD in cycle 1, 26 SUB_SHL cycles, HOLD in FIXUP, done in cycle 29.
REQ-034 dbl=1, a2 toggling each cycle -> funcs alternate SUB_SHL/ADD_SHL, done in cycle 58, iter_cnt reaches 0 in the last ITER cycle.
REQ-035 fpuhold high for 3 cycles mid-ITER -> funcs HOLD and iter_cnt frozen during the stall, done in cycle 32 (single).
REQ-036 abort in ITER cycle 10 -> IDLE next cycle, no done; a start issued 2 cycles later completes normally.
REQ-037 Macro defined, manzero=1 and a2=0 at ITER cycle 5 -> DONE next cycle with exact=1; macro undefined -> done in cycle 29 with exact=0.
REQ-038 reset_l low mid-ITER -> all outputs reset immediately, without waiting for a clock edge.
